// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the register file's writeback ports among NUM_REQ producers. Each
// cycle a leader is picked round-robin, then further requests that carry the
// same ptcid and opsize as the leader are packed onto the remaining ports.
// The regfile accepts only one ptcid and one opsize per cycle, so anything
// that does not match waits. The packed set is registered onto the wb bus one
// cycle after the grant.
//
// Ports
//   clk            system clock
//   clr            synchronous active-high reset
//   req_valid      per-requester write pending                 [NUM_REQ]
//   req_addr       destination register, requester i at [3i+2:3i]
//   req_data       write data, DATA_WIDTH per requester
//   req_size       write opsize, 2 bits per requester
//   req_ptcid      producing instruction ptcid, 7 bits per requester
//   hold           suppress all grants this cycle
//   req_ready      combinational grant (transfer = valid & ready at edge)
//   wb_data        registered port data, slot k at [DW*(k+1)-1:DW*k]
//   wb_addr        registered port addresses, 3 bits per slot
//   wb_regld       registered per-port load enables
//   wb_opsize      registered shared opsize
//   wb_inst_ptcid  registered shared ptcid
//   busy           registered; a valid request went ungranted last cycle
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int PTR_W      = 2
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [3*NUM_REQ-1:0]            req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]            req_size,
    input  logic [7*NUM_REQ-1:0]            req_ptcid,
    input  logic                            hold,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH*NUM_PORTS-1:0] wb_data,
    output logic [3*NUM_PORTS-1:0]          wb_addr,
    output logic [NUM_PORTS-1:0]            wb_regld,
    output logic [1:0]                      wb_opsize,
    output logic [6:0]                      wb_inst_ptcid,
    output logic                            busy
);

    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   sel;
    logic [NUM_PORTS-1:0] slot_vld;
    logic [PTR_W-1:0]     slot_src [NUM_PORTS];
    logic [PTR_W-1:0]     leader;
    logic                 found;

    // Selection: leader is the first valid requester in rotation order from
    // rr_ptr; companions are scanned in rotation order after the leader. An
    // address already claimed by an earlier selection blocks the later one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             clash;
        int               cnt;

        sel      = '0;
        slot_vld = '0;
        for (int k = 0; k < NUM_PORTS; k++) slot_src[k] = '0;
        leader   = '0;
        found    = 1'b0;
        idx      = '0;
        clash    = 1'b0;
        cnt      = 0;

        if (!clr && !hold) begin
            for (int o = 0; o < NUM_REQ; o++) begin
                // Explicit modulo so non-power-of-two NUM_REQ wraps correctly.
                idx = PTR_W'((int'(rr_ptr) + o) % NUM_REQ);
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    leader = idx;
                end
            end

            if (found) begin
                sel[leader] = 1'b1;
                slot_vld[0] = 1'b1;
                slot_src[0] = leader;
                cnt         = 1;
                for (int o = 1; o < NUM_REQ; o++) begin
                    idx = PTR_W'((int'(leader) + o) % NUM_REQ);
                    if (req_valid[idx] && cnt < NUM_PORTS &&
                        req_ptcid[7*idx +: 7] == req_ptcid[7*leader +: 7] &&
                        req_size[2*idx +: 2]  == req_size[2*leader +: 2]) begin
                        clash = 1'b0;
                        for (int k = 0; k < NUM_PORTS; k++) begin
                            if (slot_vld[k] &&
                                req_addr[3*slot_src[k] +: 3] == req_addr[3*idx +: 3])
                                clash = 1'b1;
                        end
                        if (!clash) begin
                            sel[idx] = 1'b1;
                            for (int k = 0; k < NUM_PORTS; k++) begin
                                if (k == cnt) begin
                                    slot_vld[k] = 1'b1;
                                    slot_src[k] = idx;
                                end
                            end
                            cnt = cnt + 1;
                        end
                    end
                end
            end
        end
    end

    assign req_ready = sel;

    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr        <= '0;
            wb_regld      <= '0;
            wb_data       <= '0;
            wb_addr       <= '0;
            wb_opsize     <= '0;
            wb_inst_ptcid <= '0;
            busy          <= 1'b0;
        end else begin
            // hold and "nothing valid" both leave sel empty, so busy reduces
            // to "some valid request was not granted".
            busy     <= |(req_valid & ~sel);
            wb_regld <= slot_vld;
            if (found) begin
                rr_ptr        <= PTR_W'((int'(leader) + 1) % NUM_REQ);
                wb_opsize     <= req_size[2*leader +: 2];
                wb_inst_ptcid <= req_ptcid[7*leader +: 7];
                // Unused slots keep their previous payload.
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (slot_vld[k]) begin
                        wb_addr[3*k +: 3] <= req_addr[3*slot_src[k] +: 3];
                        wb_data[DATA_WIDTH*k +: DATA_WIDTH] <=
                            req_data[DATA_WIDTH*slot_src[k] +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int NR = 4;
    localparam int NP = 4;
    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           clr;
    logic           hold;
    logic [NR-1:0]  req_valid;
    logic [3*NR-1:0]  req_addr;
    logic [DW*NR-1:0] req_data;
    logic [2*NR-1:0]  req_size;
    logic [7*NR-1:0]  req_ptcid;
    logic [NR-1:0]    req_ready;
    logic [DW*NP-1:0] wb_data;
    logic [3*NP-1:0]  wb_addr;
    logic [NP-1:0]    wb_regld;
    logic [1:0]       wb_opsize;
    logic [6:0]       wb_inst_ptcid;
    logic             busy;

    wb_port_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .DATA_WIDTH(DW), .PTR_W(2)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size), .req_ptcid(req_ptcid),
        .hold(hold), .req_ready(req_ready), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_regld(wb_regld), .wb_opsize(wb_opsize), .wb_inst_ptcid(wb_inst_ptcid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Per-requester stimulus
    logic [NR-1:0] tv;
    logic [2:0]    ta [NR];
    logic [DW-1:0] td [NR];
    logic [1:0]    ts [NR];
    logic [6:0]    tp [NR];

    always_comb begin
        req_valid = tv;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        req_ptcid = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[3*i +: 3]   = ta[i];
            req_data[DW*i +: DW] = td[i];
            req_size[2*i +: 2]   = ts[i];
            req_ptcid[7*i +: 7]  = tp[i];
        end
    end

    // Reference model state
    int            m_ptr;
    logic [NP-1:0] m_regld;
    logic [2:0]    m_addr [NP];
    logic [DW-1:0] m_data [NP];
    logic [1:0]    m_size;
    logic [6:0]    m_ptcid;
    logic          m_busy;

    logic [NR-1:0] g_rdy;
    int            g_ord [$];

    int total  = 0;
    int passed = 0;

    // Grant set from the rules: walk the rotation from the pointer, take the
    // first valid as leader, then walk from the leader accepting matching
    // requests whose address is not yet in the chosen-address list.
    function automatic void model_grant();
        int         lead;
        logic [2:0] used [$];
        bit         dup;
        g_rdy = '0;
        g_ord.delete();
        if (clr || hold) return;
        lead = -1;
        for (int o = 0; o < NR; o++)
            if (lead < 0 && tv[(m_ptr + o) % NR]) lead = (m_ptr + o) % NR;
        if (lead < 0) return;
        for (int o = 0; o < NR; o++) begin
            int c;
            c = (lead + o) % NR;
            dup = 0;
            foreach (used[u]) if (used[u] == ta[c]) dup = 1;
            if (tv[c] && tp[c] == tp[lead] && ts[c] == ts[lead] && !dup &&
                g_ord.size() < NP) begin
                g_ord.push_back(c);
                used.push_back(ta[c]);
                g_rdy[c] = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        model_grant();
        @(posedge clk);
        if (clr) begin
            m_ptr = 0; m_regld = '0; m_size = '0; m_ptcid = '0; m_busy = 0;
            for (int k = 0; k < NP; k++) begin m_addr[k] = '0; m_data[k] = '0; end
        end else begin
            m_busy  = |(tv & ~g_rdy);
            m_regld = '0;
            if (g_ord.size() > 0) begin
                foreach (g_ord[k]) begin
                    m_regld[k] = 1'b1;
                    m_addr[k]  = ta[g_ord[k]];
                    m_data[k]  = td[g_ord[k]];
                end
                m_size  = ts[g_ord[0]];
                m_ptcid = tp[g_ord[0]];
                m_ptr   = (g_ord[0] + 1) % NR;
            end
        end
        #1;
    endtask

    // Moves the pointer to `target` by granting a single requester.
    task automatic set_ptr(input int target);
        tv = '0;
        tv[(target + NR - 1) % NR] = 1'b1;
        tick();
        tv = '0;
    endtask

    task automatic distinct_all();
        for (int i = 0; i < NR; i++) begin
            tv[i] = 1'b1; ta[i] = 3'(i); td[i] = 64'(i + 100);
            ts[i] = 2'd1; tp[i] = 7'(i + 40);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; hold = 1'b0;
        distinct_all();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
            else passed++;
            tick();
            total++;
            if (wb_regld !== 4'b0000 || busy !== 1'b0)
                $display("FAIL reset_regs: regld=%b busy=%b want 0000/0", wb_regld, busy);
            else passed++;
        end
        clr = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        else passed++;
        tick();
        tv = '0;
        tick();
    endtask

    task automatic test_single();
        set_ptr(0);
        tv = 4'b0100; ta[2] = 3'd3; td[2] = 64'h12345678; ts[2] = 2'b10; tp[2] = 7'h05;
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready);
        else passed++;
        tick();
        tv = '0;
        total++;
        if (wb_regld !== 4'b0001 || wb_addr[2:0] !== 3'd3 || wb_data[63:0] !== 64'h12345678 ||
            wb_opsize !== 2'b10 || wb_inst_ptcid !== 7'h05)
            $display("FAIL single_wb: regld=%b addr=%0d data=%h size=%b ptcid=%h", wb_regld,
                     wb_addr[2:0], wb_data[63:0], wb_opsize, wb_inst_ptcid);
        else passed++;
        distinct_all();
        #1;
        total++;
        if (req_ready !== 4'b1000) $display("FAIL single_ptr: got %b want 1000", req_ready);
        else passed++;
        tick();
        tv = '0;
    endtask

    task automatic test_full_pack();
        set_ptr(1);
        for (int i = 0; i < NR; i++) begin
            tv[i] = 1'b1; ta[i] = 3'(i); td[i] = 64'(i * 16 + 7); ts[i] = 2'b11; tp[i] = 7'h11;
        end
        #1;
        total++;
        if (req_ready !== 4'b1111) $display("FAIL pack_ready: got %b want 1111", req_ready);
        else passed++;
        tick();
        tv = '0;
        total++;
        if (wb_regld !== 4'b1111 || wb_addr !== {3'd0, 3'd3, 3'd2, 3'd1} ||
            wb_data[63:0] !== 64'd23)
            $display("FAIL pack_wb: regld=%b addr=%h slot0=%0d want 1111/%h/23",
                     wb_regld, wb_addr, wb_data[63:0], {3'd0, 3'd3, 3'd2, 3'd1});
        else passed++;
        distinct_all();
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL pack_ptr: got %b want 0100", req_ready);
        else passed++;
        tick();
        tv = '0;
    endtask

    task automatic test_ptcid_split();
        set_ptr(0);
        distinct_all();
        tv = 4'b0011; tp[0] = 7'd1; tp[1] = 7'd2;
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL split_a: got %b want 0001", req_ready);
        else passed++;
        tick();
        tv[0] = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL split_busy_a: got %b want 1", busy);
        else passed++;
        total++;
        if (req_ready !== 4'b0010) $display("FAIL split_b: got %b want 0010", req_ready);
        else passed++;
        tick();
        tv = '0;
        total++;
        if (busy !== 1'b0 || wb_regld !== 4'b0001 || wb_inst_ptcid !== 7'd2)
            $display("FAIL split_busy_b: busy=%b regld=%b ptcid=%0d want 0/0001/2",
                     busy, wb_regld, wb_inst_ptcid);
        else passed++;
    endtask

    task automatic test_collision();
        set_ptr(0);
        distinct_all();
        tv = 4'b0011; ta[0] = 3'd5; ta[1] = 3'd5; tp[1] = tp[0];
        #1;
        total++;
        if (req_ready !== 4'b0001) $display("FAIL coll_first: got %b want 0001", req_ready);
        else passed++;
        tick();
        tv[0] = 1'b0;
        total++;
        if (req_ready !== 4'b0010) $display("FAIL coll_second: got %b want 0010", req_ready);
        else passed++;
        tick();
        tv = '0;
        total++;
        if (wb_regld !== 4'b0001 || wb_addr[2:0] !== 3'd5 || wb_data[63:0] !== 64'd101)
            $display("FAIL coll_wb: regld=%b addr=%0d data=%0d want 0001/5/101",
                     wb_regld, wb_addr[2:0], wb_data[63:0]);
        else passed++;
    endtask

    task automatic test_hold();
        set_ptr(2);
        distinct_all();
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) $display("FAIL hold_ready: got %b want 0000", req_ready);
            else passed++;
            tick();
            total++;
            if (wb_regld !== 4'b0000 || busy !== 1'b1)
                $display("FAIL hold_regs: regld=%b busy=%b want 0000/1", wb_regld, busy);
            else passed++;
        end
        hold = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0100) $display("FAIL hold_resume: got %b want 0100", req_ready);
        else passed++;
        tick();
        tv = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!tv[i] && $urandom_range(0, 3) != 0) begin
                    tv[i] = 1'b1;
                    ta[i] = 3'($urandom_range(0, 3));
                    td[i] = {$urandom, $urandom};
                    ts[i] = 2'($urandom_range(0, 1));
                    tp[i] = 7'($urandom_range(0, 1));
                end
            end
            hold = ($urandom_range(0, 9) == 0);
            clr  = ($urandom_range(0, 49) == 0);
            model_grant();
            #1;
            total++;
            if (req_ready !== g_rdy) $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, g_rdy);
            else passed++;
            tick();
            tv = tv & ~g_rdy;
            total++;
            if (wb_regld !== m_regld || busy !== m_busy || wb_opsize !== m_size ||
                wb_inst_ptcid !== m_ptcid)
                $display("FAIL rand_ctrl c=%0d: regld=%b/%b busy=%b/%b size=%b/%b ptcid=%h/%h",
                         c, wb_regld, m_regld, busy, m_busy, wb_opsize, m_size,
                         wb_inst_ptcid, m_ptcid);
            else passed++;
            for (int k = 0; k < NP; k++) begin
                total++;
                if (wb_addr[3*k +: 3] !== m_addr[k] || wb_data[DW*k +: DW] !== m_data[k])
                    $display("FAIL rand_slot c=%0d k=%0d: addr=%0d/%0d data=%h/%h", c, k,
                             wb_addr[3*k +: 3], m_addr[k], wb_data[DW*k +: DW], m_data[k]);
                else passed++;
            end
        end
        clr = 1'b0; hold = 1'b0; tv = '0;
        tick();
    endtask

    initial begin
        clr = 1'b1; hold = 1'b0; tv = '0;
        for (int i = 0; i < NR; i++) begin ta[i] = '0; td[i] = '0; ts[i] = '0; tp[i] = '0; end
        m_ptr = 0; m_regld = '0; m_size = '0; m_ptcid = '0; m_busy = 0;
        for (int k = 0; k < NP; k++) begin m_addr[k] = '0; m_data[k] = '0; end
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_full_pack();
        test_ptcid_split();
        test_collision();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's four writeback ports among NUM_REQ writeback producers (ALU, FP, memory-return, rep/string unit). Each cycle it picks a leader by round-robin. It packs companion requests that carry the same ptcid and opsize as the leader, because the regfile takes one ptcid and one opsize per cycle. The packed write set is registered onto the regfile wb bus: wb_data*, wb_addr*, wb_regld, wb_opsize, wb_inst_ptcid.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8).
NUM_PORTS, 4, regfile write ports driven; must be <= NUM_REQ.
DATA_WIDTH, 64, writeback data width per port.
PTR_W, 2, round-robin pointer width; must equal ceil(log2(NUM_REQ)).

Ports:
clk  in  1  system clock; all state updates on rising edge.
clr  in  1  reset, synchronous, active-high.
req_valid  in  NUM_REQ  per-requester write pending.
req_addr  in  3*NUM_REQ  destination register address, requester i at [3i+2:3i].
req_data  in  DATA_WIDTH*NUM_REQ  write data.
req_size  in  2*NUM_REQ  write opsize (regfile encoding).
req_ptcid  in  7*NUM_REQ  ptcid of the producing instruction.
hold  in  1  suppress all grants this cycle (flush / ptc_clear window).
req_ready  out  NUM_REQ  combinational grant; a transfer occurs when valid & ready at the edge.
wb_data  out  DATA_WIDTH*NUM_PORTS  registered port data, slot k at [DATA_WIDTH*(k+1)-1:DATA_WIDTH*k].
wb_addr  out  3*NUM_PORTS  registered port addresses.
wb_regld  out  NUM_PORTS  registered per-port load enables.
wb_opsize  out  2  registered shared opsize.
wb_inst_ptcid  out  7  registered shared ptcid.
busy  out  1  registered; 1 if any valid request was left ungranted last cycle.

Behaviour:
- Reset (clr=1 at edge): rr_ptr=0; wb_regld=0; wb_data, wb_addr, wb_opsize, wb_inst_ptcid=0; busy=0. req_ready=0 while clr=1.
- Leader: first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- Companions: scan continues from leader+1 in rotation order. Requester j is granted only if all of the following hold:
  - req_valid[j]=1.
  - req_ptcid[j]==leader ptcid.
  - req_size[j]==leader size.
  - req_addr[j] differs from every already-selected address.
  - Fewer than NUM_PORTS are already selected.
- On an address collision, the earlier one in rotation order wins; the later one waits.
- req_ready = selected set; purely combinational from req_* inputs, rr_ptr, hold and clr.
- Requesters hold valid and payload stable until ready. Valid must not depend on ready.
- Latency: grant in cycle N → wb_* valid in cycle N+1.
- Slot packing: leader in slot 0, companions in slots 1.. in selection order; unused slots get wb_regld=0.
- Payload of unused slots holds its previous value; wb_opsize/wb_inst_ptcid hold when no grant.
- rr_ptr update on any grant: (leader+1) mod NUM_REQ. Pointer advances past the leader only; companions do not move it. No grant: rr_ptr holds.
- hold=1:
  - req_ready=0 and wb_regld<=0 next cycle.
  - rr_ptr holds.
  - busy<=1 if any req_valid.
- No valid requests: wb_regld<=0, busy<=0.
- Reset mid-stream: clr overrides hold and requests. Any grant combinationally visible that cycle is not transferred; producers must re-present.
- NUM_REQ not a power of two: pointer wrap uses explicit modulo, never plain overflow.

Test Plan:
- Reset: clr=1 for 2 cycles with all req_valid=1 → req_ready=0000, wb_regld=0000 and busy=0 after each edge. Release clr → first grant starts at requester 0.
- Single write: only req2 valid (addr=3, data=0x12345678, size=2'b10, ptcid=7'h05), rr_ptr=0 → req_ready=0100 same cycle. Next cycle: wb_regld=0001, wb_addr[2:0]=3, wb_data slot0=0x12345678, wb_opsize=2'b10, wb_inst_ptcid=7'h05; rr_ptr=3.
- Full pack: all four valid, ptcid 7'h11, size 2'b11, addrs 0,1,2,3, rr_ptr=1 → req_ready=1111. Next cycle wb_regld=1111 with slots holding addrs 1,2,3,0; rr_ptr=2.
- ptcid split: req0 ptcid 1, req1 ptcid 2, both held valid, rr_ptr=0 → cycle A grants 0001, rr_ptr=1. Cycle B grants 0010, rr_ptr=2. busy=1 after A, 0 after B.
- Address collision: req0 and req1 valid, same ptcid/size, both addr 5, rr_ptr=0 → grant 0001 only. Next cycle grant 0010; no cycle ever has both.
- Hold: requests pending, hold=1 for 3 cycles → req_ready=0, wb_regld=0, rr_ptr unchanged, busy=1. Drop hold → normal grant resumes from the unchanged rr_ptr.
